pps_period_meter: RTL and testbench

- Measures the PPS period in clk cycles and presents it as an 8-digit packed BCD value with a single-cycle strobe.
- Sits directly upstream of the BCD-to-UART formatter: count_bcd drives its data input and count_strobe drives its data_strobe.
- Adds arming after reset, missing-PPS timeout, saturation/overflow flagging and a lock indicator against a nominal period.

---
 rtl/pps_period_meter.sv | 212 +++++++++++++++++++++
 tb/tb_pps_period_meter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pps_period_meter.sv
// PPS period meter: measures the PPS period in clk cycles as packed BCD.
// Optional PPS_DEBOUNCE_EN adds a glitch filter after the synchroniser.
module pps_period_meter #(
  parameter int DIGITS        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int NOMINAL       = 12000000,
  parameter int TOL           = 1200,
  parameter int TIMEOUT       = 24000000,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pps,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                count_strobe,
  output logic                overflow,
  output logic                pps_lost,
  output logic                locked
);

  localparam int W = 4 * DIGITS;

  localparam logic [31:0] LO      = 32'(NOMINAL - TOL);
  localparam logic [31:0] HI      = 32'(NOMINAL + TOL);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] B_MAX   = '1;

  if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1) begin : g_bad_param
    $error("pps_period_meter: SYNC_STAGES >= 2, GLITCH_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOST
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic                   level_q;
  logic                   edge_q;

  logic [W-1:0]  r_cnt;
  logic [31:0]   b_cnt;
  logic          sat;
  logic          in_rng;
  logic [1:0]    rng_cnt;

  logic          publish;
  logic          to_lost;
  logic          rearm;

  // Parallel-carry BCD increment; digit k steps when all lower digits are 9.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         all9;
    res  = v;
    all9 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (all9) begin
        if (v[4*k +: 4] == 4'd9) res[4*k +: 4] = 4'd0;
        else                     res[4*k +: 4] = v[4*k +: 4] + 4'd1;
      end
      all9 = all9 & (v[4*k +: 4] == 4'd9);
    end
    return res;
  endfunction

  // Metastability synchroniser for the raw asynchronous pps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pps};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PPS_DEBOUNCE_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);

  logic [GW-1:0] glitch_cnt;

  // Level follows synced only after GLITCH_CYCLES equal samples in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level      <= 1'b0;
      glitch_cnt <= '0;
    end else if (synced == level) begin
      glitch_cnt <= '0;
    end else if (glitch_cnt == GW'(GLITCH_CYCLES - 1)) begin
      level      <= synced;
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`else
  assign level = synced;
`endif

  // One-cycle rising-edge pulse; fixed latency keeps the period exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      level_q <= level;
      edge_q  <= level & ~level_q;
    end
  end

  // Saturation of the BCD counter and lock window test on the binary one.
  always_comb begin
    sat = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      sat = sat & (r_cnt[4*k +: 4] == 4'd9);
    end
    in_rng = (b_cnt >= LO) && (b_cnt <= HI);
  end

  // Running counters: restart at 1 on every edge, otherwise saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      b_cnt <= '0;
    end else if (edge_q) begin
      r_cnt <= W'(1);
      b_cnt <= 32'd1;
    end else begin
      if (!sat)          r_cnt <= bcd_inc(r_cnt);
      if (b_cnt != B_MAX) b_cnt <= b_cnt + 32'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle actions; an edge beats a timeout.
  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    to_lost   = 1'b0;
    rearm     = 1'b0;
    unique case (state)
      IDLE: begin
        if (edge_q) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (edge_q) begin
          publish = 1'b1;
        end else if (b_cnt >= TO_LAST) begin
          state_nxt = LOST;
          to_lost   = 1'b1;
        end
      end
      LOST: begin
        if (edge_q) begin
          state_nxt = MEASURE;
          rearm     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Published result, overflow flag and strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_bcd    <= '0;
      count_strobe <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      count_strobe <= publish;
      if (publish) begin
        count_bcd <= r_cnt;
        overflow  <= sat;
      end
    end
  end

  // Lock tracking and loss-of-signal flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rng_cnt  <= 2'd0;
      locked   <= 1'b0;
      pps_lost <= 1'b0;
    end else begin
      if (publish) begin
        if (in_rng) begin
          if (rng_cnt != 2'd2) rng_cnt <= rng_cnt + 2'd1;
          locked <= (rng_cnt != 2'd0);
        end else begin
          rng_cnt <= 2'd0;
          locked  <= 1'b0;
        end
      end
      if (to_lost) begin
        pps_lost <= 1'b1;
        locked   <= 1'b0;
        rng_cnt  <= 2'd0;
      end
      if (rearm) pps_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pps_period_meter.sv
// Directed bench for pps_period_meter (NOMINAL=100, TOL=2, TIMEOUT=250).
// A second instance with DIGITS=2 covers saturation.
module tb_pps_period_meter;

  localparam int TO = 250;
`ifdef PPS_DEBOUNCE_EN
  localparam int LAT   = 2 + 4 + 1;
  localparam int G_MID = 0;
  localparam int G_B_N = 1;
  localparam int G_B_V = 32'h100;
  localparam int G_C_N = 2;
`else
  localparam int LAT   = 2 + 1;
  localparam int G_MID = 1;
  localparam int G_B_N = 2;
  localparam int G_B_V = 32'h50;
  localparam int G_C_N = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pps = 1'b0;

  logic [31:0] count_bcd;
  logic        count_strobe;
  logic        overflow;
  logic        pps_lost;
  logic        locked;

  logic [7:0]  count_bcd2;
  logic        count_strobe2;
  logic        overflow2;
  logic        pps_lost2;
  logic        locked2;

  int n_chk = 0;
  int n_fail = 0;
  int strobes = 0;
  int strobes2 = 0;
  int n0;
  int n2;
  logic [31:0] last_bcd = '0;

  pps_period_meter #(
    .DIGITS(8), .SYNC_STAGES(2), .NOMINAL(100),
    .TOL(2), .TIMEOUT(250), .GLITCH_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pps(pps),
    .count_bcd(count_bcd), .count_strobe(count_strobe),
    .overflow(overflow), .pps_lost(pps_lost), .locked(locked)
  );

  pps_period_meter #(
    .DIGITS(2), .SYNC_STAGES(2), .NOMINAL(100),
    .TOL(2), .TIMEOUT(1000), .GLITCH_CYCLES(4)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .pps(pps),
    .count_bcd(count_bcd2), .count_strobe(count_strobe2),
    .overflow(overflow2), .pps_lost(pps_lost2), .locked(locked2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_strobe) begin
      strobes++;
      last_bcd = count_bcd;
    end
    if (count_strobe2) strobes2++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rise now; next rise comes n cycles later.
  task automatic pulse(input int n);
    pps = 1'b1;
    tick(5);
    pps = 1'b0;
    tick(n - 5);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(2);
    check("rst_bcd", count_bcd, 32'h0);
    check("rst_strobe", 32'(count_strobe), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_lost", 32'(pps_lost), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_bcd2", 32'(count_bcd2), 32'h0);
    reset_n = 1'b1;

    // arming
    tick(10);
    n0 = strobes;
    pulse(100);
    check("arm_no_strobe", 32'(strobes - n0), 32'd0);
    pulse(20);
    check("arm_strobes", 32'(strobes - n0), 32'd1);
    check("arm_last", last_bcd, 32'h100);
    check("arm_bcd", count_bcd, 32'h100);
    check("arm_ovf", 32'(overflow), 32'h0);

    // lock
    do_reset();
    tick(10);
    n0 = strobes;
    pulse(100);
    pulse(101);
    check("lock1_locked", 32'(locked), 32'h0);
    check("lock1_bcd", count_bcd, 32'h100);
    pulse(99);
    check("lock2_locked", 32'(locked), 32'h1);
    check("lock2_bcd", count_bcd, 32'h101);
    pulse(110);
    check("lock3_locked", 32'(locked), 32'h1);
    check("lock3_bcd", count_bcd, 32'h99);
    pulse(20);
    check("unlock_locked", 32'(locked), 32'h0);
    check("unlock_bcd", count_bcd, 32'h110);
    check("lock_strobes", 32'(strobes - n0), 32'd4);

    // timeout: pps_lost first high TIMEOUT cycles after the internal edge
    do_reset();
    tick(10);
    n0 = strobes;
    pps = 1'b1;
    tick(5);
    pps = 1'b0;
    tick(LAT + TO - 1 - 5);
    check("to_before", 32'(pps_lost), 32'h0);
    tick(1);
    check("to_at", 32'(pps_lost), 32'h1);
    check("to_locked", 32'(locked), 32'h0);
    tick(300 - LAT - TO);
    check("to_no_strobe", 32'(strobes - n0), 32'd0);
    pulse(100);
    check("to_cleared", 32'(pps_lost), 32'h0);
    check("to_rearm_nostb", 32'(strobes - n0), 32'd0);
    pulse(20);
    check("to_strobes", 32'(strobes - n0), 32'd1);
    check("to_bcd", count_bcd, 32'h100);

    // saturation on the 2-digit instance
    do_reset();
    tick(10);
    n2 = strobes2;
    pulse(150);
    pulse(50);
    check("sat_strobes", 32'(strobes2 - n2), 32'd1);
    check("sat_bcd", 32'(count_bcd2), 32'h99);
    check("sat_ovf", 32'(overflow2), 32'h1);
    check("sat_wide_bcd", count_bcd, 32'h150);
    check("sat_wide_ovf", 32'(overflow), 32'h0);
    pulse(20);
    check("sat_after_bcd", 32'(count_bcd2), 32'h50);
    check("sat_after_ovf", 32'(overflow2), 32'h0);

    // asynchronous reset mid-period
    do_reset();
    tick(10);
    pulse(100);
    pulse(100);
    pps = 1'b1;
    tick(5);
    pps = 1'b0;
    tick(45);
    check("pre_rst_locked", 32'(locked), 32'h1);
    check("pre_rst_bcd", count_bcd, 32'h100);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_bcd", count_bcd, 32'h0);
    check("arst_locked", 32'(locked), 32'h0);
    check("arst_strobe", 32'(count_strobe), 32'h0);
    check("arst_lost", 32'(pps_lost), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(10);
    n0 = strobes;
    pulse(100);
    check("arst_arm_only", 32'(strobes - n0), 32'd0);
    pulse(20);
    check("arst_strobes", 32'(strobes - n0), 32'd1);
    check("arst_meas", count_bcd, 32'h100);
    check("arst_unlocked", 32'(locked), 32'h0);

    // 2-cycle glitch at 50, 10-cycle pulse at 100, pulse at 200
    do_reset();
    tick(10);
    n0 = strobes;
    pps = 1'b1;
    tick(5);
    pps = 1'b0;
    tick(45);
    pps = 1'b1;
    tick(2);
    pps = 1'b0;
    tick(20);
    check("glitch_mid", 32'(strobes - n0), 32'(G_MID));
    tick(28);
    pps = 1'b1;
    tick(10);
    pps = 1'b0;
    tick(90);
    check("glitch_b_n", 32'(strobes - n0), 32'(G_B_N));
    check("glitch_b_v", last_bcd, 32'(G_B_V));
    pulse(20);
    check("glitch_c_n", 32'(strobes - n0), 32'(G_C_N));
    check("glitch_c_v", last_bcd, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
